// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg: opcodes, funct3 codes, FSM states and alignment helpers for the memory stage.
package memory_stage_pkg;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [2:0] FUNC_LB  = 3'd0;
   localparam logic [2:0] FUNC_LH  = 3'd1;
   localparam logic [2:0] FUNC_LW  = 3'd2;
   localparam logic [2:0] FUNC_LBU = 3'd4;
   localparam logic [2:0] FUNC_LHU = 3'd5;
   localparam logic [2:0] FUNC_SB  = 3'd0;
   localparam logic [2:0] FUNC_SH  = 3'd1;
   localparam logic [2:0] FUNC_SW  = 3'd2;
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;
   function automatic logic is_mem(input logic [6:0] op);
      return op == OP_LOAD || op == OP_STORE;
   endfunction
   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      return f3[1:0] == 2'b01 ? off[0] : f3[1:0] == 2'b10 ? |off : 1'b0;
   endfunction
endpackage

// File: rtl/memory_stage_lsu_align.sv
// memory_stage_lsu_align: store lane steering and strobes, load lane extraction with sign/zero extension.
module memory_stage_lsu_align (
   input  logic [2:0]  func3,
   input  logic [1:0]  off,
   input  logic [31:0] sdata,
   input  logic [31:0] rdata,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic [31:0] ldata
);
   logic [1:0]  eoff;
   logic [15:0] lane;
   logic        sx;
   // offsets are truncated to natural alignment; misaligned traps are decided upstream
   always_comb begin
      eoff  = func3[1:0] == 2'b10 ? 2'b00 : func3[1:0] == 2'b01 ? {off[1], 1'b0} : off;
      lane  = 16'(rdata >> {eoff, 3'b000});
      sx    = ~func3[2];
      wdata = func3[1:0] == 2'b00 ? {4{sdata[7:0]}} : func3[1:0] == 2'b01 ? {2{sdata[15:0]}} : sdata;
      wstrb = func3[1:0] == 2'b00 ? 4'b0001 << eoff : func3[1:0] == 2'b01 ? 4'b0011 << eoff : 4'hF;
      ldata = func3[1:0] == 2'b00 ? {{24{sx & lane[7]}}, lane[7:0]} :
              func3[1:0] == 2'b01 ? {{16{sx & lane[15]}}, lane} : rdata;
   end
endmodule

// File: rtl/memory_stage.sv
// memory_stage: pipeline stage 4, runs loads/stores over a req/gnt/rvalid data bus.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of truncating the address.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int RESP_TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              e_to_m_valid,
   output logic              m_allow_in,
   output logic              m_valid,
   output logic              m_to_w_valid,
   input  logic              w_allow_in,
   input  logic [6:0]        E_opcode,
   input  logic [2:0]        e_func3,
   input  logic [31:0]       e_valE,
   input  logic [31:0]       E_val2,
   input  logic [4:0]        E_rd,
   input  logic [31:0]       E_pc,
   input  logic [31:0]       E_instr,
   input  logic              E_commit,
   output logic [6:0]        M_opcode,
   output logic [4:0]        M_rd,
   output logic [31:0]       M_pc,
   output logic [31:0]       M_instr,
   output logic              M_commit,
   output logic [31:0]       M_valE,
   output logic [31:0]       m_valM,
   output logic              m_misalign,
   output logic              m_bus_err,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   output logic [3:0]        dmem_wstrb,
   input  logic              dmem_gnt,
   input  logic              dmem_rvalid,
   input  logic [31:0]       dmem_rdata
);
   state_t      state;
   logic [2:0]  m_func3;
   logic [31:0] m_val2, cnt, ldata;
   logic [3:0]  wstrb;
   logic        m_ready_go, accept, e_trap;
   assign m_ready_go   = ~is_mem(M_opcode) | state == S_DONE;
   assign m_allow_in   = ~m_valid | (m_ready_go & w_allow_in);
   assign m_to_w_valid = m_valid & m_ready_go;
   assign accept       = m_allow_in & e_to_m_valid;
`ifdef MEM_MISALIGN_TRAP_EN
   assign e_trap = is_mem(E_opcode) & misaligned(e_func3, e_valE[1:0]);
`else
   assign e_trap = 1'b0;
`endif
   // bus fields come straight from the latches, so they stay stable until granted
   assign dmem_req   = state == S_REQ;
   assign dmem_we    = dmem_req & M_opcode == OP_STORE;
   assign dmem_addr  = {M_valE[ADDR_W-1:2], 2'b00};
   assign dmem_wstrb = dmem_we ? wstrb : 4'h0;
   memory_stage_lsu_align u_align (
      .func3(m_func3),
      .off  (M_valE[1:0]),
      .sdata(m_val2),
      .rdata(dmem_rdata),
      .wdata(dmem_wdata),
      .wstrb(wstrb),
      .ldata(ldata)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         m_valid    <= 1'b0;
         M_opcode   <= '0;
         m_func3    <= '0;
         M_valE     <= '0;
         m_val2     <= '0;
         M_rd       <= '0;
         M_pc       <= '0;
         M_instr    <= '0;
         M_commit   <= 1'b0;
         m_valM     <= '0;
         m_misalign <= 1'b0;
         m_bus_err  <= 1'b0;
         cnt        <= '0;
      end else begin
         if (m_allow_in) begin
            m_valid    <= e_to_m_valid;
            m_bus_err  <= 1'b0;
            m_misalign <= 1'b0;
         end
         if (accept) begin
            M_opcode   <= E_opcode;
            m_func3    <= e_func3;
            M_valE     <= e_valE;
            m_val2     <= E_val2;
            M_rd       <= E_rd;
            M_pc       <= E_pc;
            M_instr    <= E_instr;
            M_commit   <= E_commit;
            m_valM     <= '0;
            m_misalign <= e_trap;
            state      <= is_mem(E_opcode) ? (e_trap ? S_DONE : S_REQ) : S_IDLE;
         end else if (m_allow_in) begin
            state <= S_IDLE;
         end else if (state == S_REQ) begin
            cnt <= '0;
            if (dmem_gnt) state <= M_opcode == OP_STORE ? S_DONE : S_WAIT;
         end else if (state == S_WAIT) begin
            cnt <= cnt + 32'd1;
            if (dmem_rvalid) begin
               m_valM <= ldata;
               state  <= S_DONE;
            end else if (RESP_TIMEOUT > 0 && cnt == 32'(RESP_TIMEOUT - 1)) begin
               m_bus_err <= 1'b1;
               m_valM    <= '0;
               state     <= S_DONE;
            end
         end
      end
   end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed checks of the memory stage handshake, bus protocol and lane logic.
module tb_memory_stage;
   import memory_stage_pkg::*;
   logic        clk = 0, rst = 1;
   logic        e_to_m_valid = 0, w_allow_in = 1;
   logic        m_allow_in, m_valid, m_to_w_valid;
   logic [6:0]  E_opcode = 0, M_opcode;
   logic [2:0]  e_func3 = 0;
   logic [31:0] e_valE = 0, E_val2 = 0, E_pc = 0, E_instr = 0;
   logic [4:0]  E_rd = 0, M_rd;
   logic        E_commit = 0, M_commit;
   logic [31:0] M_pc, M_instr, M_valE, m_valM;
   logic        m_misalign, m_bus_err, dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0;
   logic [3:0]  dmem_wstrb;
   logic        dmem_gnt = 0, dmem_rvalid = 0;
   int          errors = 0, checks = 0;
   logic [31:0] held;

   memory_stage #(.ADDR_W(32), .RESP_TIMEOUT(6)) dut (
      .clk(clk), .rst(rst), .e_to_m_valid(e_to_m_valid), .m_allow_in(m_allow_in),
      .m_valid(m_valid), .m_to_w_valid(m_to_w_valid), .w_allow_in(w_allow_in),
      .E_opcode(E_opcode), .e_func3(e_func3), .e_valE(e_valE), .E_val2(E_val2),
      .E_rd(E_rd), .E_pc(E_pc), .E_instr(E_instr), .E_commit(E_commit),
      .M_opcode(M_opcode), .M_rd(M_rd), .M_pc(M_pc), .M_instr(M_instr),
      .M_commit(M_commit), .M_valE(M_valE), .m_valM(m_valM), .m_misalign(m_misalign),
      .m_bus_err(m_bus_err), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic present(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
      e_to_m_valid = 1; E_opcode = op; e_func3 = f3; e_valE = addr; E_val2 = data;
   endtask

   // best-case load: gnt in the first REQ cycle, rvalid the next; leaves the stage on exit
   task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rdata, input logic [31:0] exp, input logic [31:0] exp_addr);
      present(OP_LOAD, f3, addr, 0);
      @(negedge clk); e_to_m_valid = 0; dmem_gnt = 1;
      chk({tag, " req"}, dmem_req, 1);
      chk({tag, " addr"}, dmem_addr, exp_addr);
      @(negedge clk); dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = rdata;
      @(negedge clk); dmem_rvalid = 0;
      chk({tag, " valM"}, m_valM, exp);
      chk({tag, " to_w"}, m_to_w_valid, 1);
      @(negedge clk);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 0;
      chk("rst valid", m_valid, 0);
      chk("rst req", dmem_req, 0);
      chk("rst allow", m_allow_in, 1);
      chk("rst wstrb", dmem_wstrb, 0);
      chk("rst valM", m_valM, 0);

      // SW, granted in the first REQ cycle
      present(OP_STORE, FUNC_SW, 32'h100, 32'hDEADBEEF);
      E_rd = 5'd7; E_pc = 32'h40; E_commit = 1;
      @(negedge clk); e_to_m_valid = 0; dmem_gnt = 1;
      chk("sw req", dmem_req, 1);
      chk("sw we", dmem_we, 1);
      chk("sw addr", dmem_addr, 32'h100);
      chk("sw wstrb", dmem_wstrb, 4'hF);
      chk("sw wdata", dmem_wdata, 32'hDEADBEEF);
      chk("sw to_w c1", m_to_w_valid, 0);
      chk("sw rd", M_rd, 7);
      chk("sw pc", M_pc, 32'h40);
      @(negedge clk); dmem_gnt = 0;
      chk("sw to_w c2", m_to_w_valid, 1);
      chk("sw req c2", dmem_req, 0);
      @(negedge clk);
      chk("sw gone", m_valid, 0);

      load("lb", FUNC_LB, 32'h103, 32'h80FF_0000, 32'hFFFFFF80, 32'h100);
      load("lbu", FUNC_LBU, 32'h103, 32'h80FF_0000, 32'h00000080, 32'h100);
      load("lh", FUNC_LH, 32'h102, 32'h8001_0000, 32'hFFFF8001, 32'h100);
      load("lhu", FUNC_LHU, 32'h102, 32'h8001_0000, 32'h00008001, 32'h100);
      load("lb0", FUNC_LB, 32'h204, 32'h0000_007F, 32'h0000007F, 32'h204);
      load("lw", FUNC_LW, 32'h100, 32'hCAFEF00D, 32'hCAFEF00D, 32'h100);

      // SH with grant withheld for three cycles
      present(OP_STORE, FUNC_SH, 32'h102, 32'h0000_1234);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); e_to_m_valid = 0;
         chk("sh req", dmem_req, 1);
         chk("sh wstrb", dmem_wstrb, 4'hC);
         chk("sh wdata", dmem_wdata, 32'h12341234);
         chk("sh allow", m_allow_in, 0);
      end
      dmem_gnt = 1;
      @(negedge clk); dmem_gnt = 0;
      chk("sh to_w", m_to_w_valid, 1);
      @(negedge clk);

      // SB into lane 1
      present(OP_STORE, FUNC_SB, 32'h301, 32'h0000_00A5);
      @(negedge clk); e_to_m_valid = 0; dmem_gnt = 1;
      chk("sb wstrb", dmem_wstrb, 4'h2);
      chk("sb wdata", dmem_wdata, 32'hA5A5A5A5);
      @(negedge clk); dmem_gnt = 0;
      @(negedge clk);

      // LW held in DONE by write-back backpressure; a waiting ALU op must not enter
      present(OP_LOAD, FUNC_LW, 32'h100, 0);
      w_allow_in = 0;
      @(negedge clk); e_to_m_valid = 0; dmem_gnt = 1;
      @(negedge clk); dmem_gnt = 0; dmem_rvalid = 1; dmem_rdata = 32'h01234567;
      @(negedge clk); dmem_rvalid = 0; dmem_rdata = 32'hFFFFFFFF;
      present(7'h33, 3'd0, 32'h55, 0);
      for (int i = 0; i < 4; i++) begin
         chk("bp valM", m_valM, 32'h01234567);
         chk("bp allow", m_allow_in, 0);
         chk("bp valE", M_valE, 32'h100);
         @(negedge clk);
      end
      w_allow_in = 1;
      @(negedge clk); e_to_m_valid = 0;
      chk("bp next op", M_opcode, 7'h33);
      chk("bp next valE", M_valE, 32'h55);
      chk("bp next to_w", m_to_w_valid, 1);
      @(negedge clk);

      // LW at offset 1
`ifdef MEM_MISALIGN_TRAP_EN
      present(OP_LOAD, FUNC_LW, 32'h101, 0);
      @(negedge clk); e_to_m_valid = 0; dmem_gnt = 1;
      chk("mis req", dmem_req, 0);
      chk("mis flag", m_misalign, 1);
      chk("mis to_w", m_to_w_valid, 1);
      chk("mis valM", m_valM, 0);
      @(negedge clk); dmem_gnt = 0;
      chk("mis gone", m_valid, 0);
`else
      load("lw mis", FUNC_LW, 32'h101, 32'h11223344, 32'h11223344, 32'h100);
      chk("mis flag", m_misalign, 0);
`endif

      // response timeout after six WAIT cycles
      load("pre", FUNC_LW, 32'h100, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h100);
      present(OP_LOAD, FUNC_LW, 32'h108, 0);
      @(negedge clk); e_to_m_valid = 0; dmem_gnt = 1;
      @(negedge clk); dmem_gnt = 0; w_allow_in = 0;
      repeat (5) @(negedge clk);
      chk("to before", m_bus_err, 0);
      chk("to before to_w", m_to_w_valid, 0);
      @(negedge clk);
      chk("to err", m_bus_err, 1);
      chk("to valM", m_valM, 0);
      chk("to to_w", m_to_w_valid, 1);
      @(negedge clk);
      chk("to err held", m_bus_err, 1);
      w_allow_in = 1;
      @(negedge clk);
      chk("to err clr", m_bus_err, 0);
      chk("to gone", m_valid, 0);

      // reset while waiting for the response
      present(OP_LOAD, FUNC_LW, 32'h100, 0);
      @(negedge clk); e_to_m_valid = 0; dmem_gnt = 1;
      @(negedge clk); dmem_gnt = 0; rst = 1;
      @(negedge clk); rst = 0;
      chk("rw valid", m_valid, 0);
      chk("rw req", dmem_req, 0);
      chk("rw allow", m_allow_in, 1);
      load("after rst", FUNC_LHU, 32'h100, 32'h0000BEEF, 32'h0000BEEF, 32'h100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
